// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-organised single-port RAM from pipeline requests,
// adding sign/zero extension, splitting of word-crossing accesses and a response pulse.
module load_store_unit #(
   parameter int XLEN             = 32,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_width,
   input  logic            req_unsigned,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_error,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_w_data,
   output logic [1:0]      mem_w_width,
   output logic            mem_w_enable,
   input  logic [XLEN-1:0] mem_r_data
);

   typedef enum logic [1:0] {
      WRITE_BYTE     = 2'b00,
      WRITE_HALFWORD = 2'b01,
      WRITE_WORD     = 2'b10
   } write_width_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_HI,
      S_ST_BYTES
   } state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_lo;
   logic [2:0]      r_size;
   logic [2:0]      r_idx;
   logic            r_unsigned;
   logic            r_respPend;
   logic            r_respLoad;
   logic            r_respErr;
   logic            r_respCross;

   logic            w_pendNext;
   logic            w_pendLoad;
   logic            w_pendErr;
   logic            w_pendCross;
   logic            w_wen;
   logic [2:0]      w_size;
   logic            w_legal;
   logic            w_cross;
   logic            w_accept;
   logic [XLEN-1:0] w_nextWord;
   logic [XLEN-1:0] w_merged;
   logic [XLEN-1:0] w_raw;
   logic [XLEN-1:0] w_ext;

   always_comb begin
      w_size  = 3'd0;
      w_legal = 1'b1;
      case (req_width)
         WRITE_BYTE:     w_size = 3'd1;
         WRITE_HALFWORD: w_size = 3'd2;
         WRITE_WORD:     w_size = 3'd4;
         default:        w_legal = 1'b0;
      endcase
   end

   assign w_cross    = ({2'b00, req_addr[1:0]} + {1'b0, w_size}) > 4'd4;
   assign req_ready  = (r_state == S_IDLE);
   assign w_accept   = req_valid && req_ready;
   assign w_nextWord = {r_addr[XLEN-1:2], 2'b00} + XLEN'(4);

   // The first RAM access of every request comes straight from the req_* inputs.
   always_comb begin
      w_stateNext = r_state;
      w_pendNext  = 1'b0;
      w_pendLoad  = 1'b0;
      w_pendErr   = 1'b0;
      w_pendCross = 1'b0;
      w_wen       = 1'b0;
      mem_addr    = req_addr;
      mem_w_data  = req_wdata;
      mem_w_width = req_width;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (!w_legal || (w_cross && !SPLIT_MISALIGNED)) begin
                  w_pendNext = 1'b1;
                  w_pendErr  = 1'b1;
               end else if (!w_cross) begin
                  w_pendNext = 1'b1;
                  w_pendLoad = !req_is_store;
                  w_wen      = req_is_store;
               end else if (!req_is_store) begin
                  w_stateNext = S_LOAD_HI;
               end else begin
                  w_wen       = 1'b1;
                  mem_w_width = WRITE_BYTE;
                  w_stateNext = S_ST_BYTES;
               end
            end
         end
         S_LOAD_HI: begin
            mem_addr    = w_nextWord;
            w_stateNext = S_IDLE;
            w_pendNext  = 1'b1;
            w_pendLoad  = 1'b1;
            w_pendCross = 1'b1;
         end
         S_ST_BYTES: begin
            mem_addr    = r_addr + XLEN'(r_idx);
            mem_w_data  = r_wdata >> {r_idx, 3'b000};
            mem_w_width = WRITE_BYTE;
            w_wen       = 1'b1;
            if (r_idx == r_size - 3'd1) begin
               w_stateNext = S_IDLE;
               w_pendNext  = 1'b1;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   assign mem_w_enable = w_wen & reset_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_stateNext;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_respPend  <= 1'b0;
         r_respLoad  <= 1'b0;
         r_respErr   <= 1'b0;
         r_respCross <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_lo        <= '0;
         r_size      <= 3'd0;
         r_idx       <= 3'd0;
         r_unsigned  <= 1'b0;
      end else begin
         r_respPend  <= w_pendNext;
         r_respLoad  <= w_pendLoad;
         r_respErr   <= w_pendErr;
         r_respCross <= w_pendCross;
         if (w_accept) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= w_size;
            r_unsigned <= req_unsigned;
            r_idx      <= 3'd1;
         end else if (r_state == S_ST_BYTES) begin
            r_idx <= r_idx + 3'd1;
         end
         if (r_state == S_LOAD_HI) r_lo <= mem_r_data;
      end
   end

   // The low read already arrives shifted down with zero-filled top bytes, so OR merges cleanly.
   assign w_merged = r_lo | (mem_r_data << {(3'd4 - {1'b0, r_addr[1:0]}), 3'b000});
   assign w_raw    = r_respCross ? w_merged : mem_r_data;

   always_comb begin
      case (r_size)
         3'd1:    w_ext = {{(XLEN-8){~r_unsigned & w_raw[7]}}, w_raw[7:0]};
         3'd2:    w_ext = {{(XLEN-16){~r_unsigned & w_raw[15]}}, w_raw[15:0]};
         default: w_ext = w_raw;
      endcase
   end

   assign resp_valid = r_respPend;
   assign resp_error = r_respPend & r_respErr;
   assign resp_rdata = (r_respPend && r_respLoad) ? w_ext : '0;

endmodule
